// File: rtl/nw_pkg.sv
// Shared types for the NW traceback emitter: move codes, emitter states, coordinate word.
// Pure declarations; no timing or flow control of its own.
package nw_pkg;

  localparam int NW_CORD_W = 8;

  // Same encoding as the grid direction codes.
  typedef enum logic [1:0] {
    MV_TOP    = 2'b00,
    MV_LEFT   = 2'b01,
    MV_CORNER = 2'b10
  } move_t;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    FLUSH,
    LAST,
    DONE,
    ERR
  } emit_state_t;

  typedef struct packed {
    logic [NW_CORD_W-1:0] x;
    logic [NW_CORD_W-1:0] y;
  } coord_t;

  function automatic logic unit_step(input logic [NW_CORD_W-1:0] d);
    return (d[NW_CORD_W-1:1] == '0);
  endfunction

endpackage

// File: rtl/nw_step_decode.sv
// Classifies one traceback step p -> c into a move and checks that it is a legal unit step.
// Combinational, zero latency; no flow control.
module nw_step_decode
  import nw_pkg::*;
#(
  parameter int LENGTH = 10
) (
  input  logic [2*NW_CORD_W-1:0] p,
  input  logic [2*NW_CORD_W-1:0] c,
  output logic [1:0]             move,
  output logic                   legal
);

  localparam logic [NW_CORD_W-1:0] LIM = NW_CORD_W'(LENGTH);

  coord_t               pc;
  coord_t               cc;
  logic [NW_CORD_W-1:0] dx;
  logic [NW_CORD_W-1:0] dy;

  assign pc = p;
  assign cc = c;
  // Wrapping subtraction: a backwards step shows up as a large delta and fails unit_step.
  assign dx = pc.x - cc.x;
  assign dy = pc.y - cc.y;

  always_comb begin
    move = MV_CORNER;
    if (dx[0] && !dy[0]) begin
      move = MV_LEFT;
    end else if (!dx[0] && dy[0]) begin
      move = MV_TOP;
    end
    legal = unit_step(dx) && unit_step(dy) && (dx[0] || dy[0]) &&
            (cc.x < LIM) && (cc.y < LIM);
  end

endmodule

// File: rtl/nw_align_emitter.sv
// Turns the NW traceback coordinate stream into aligned character pairs (end to start) plus counters; NW_SCORE_CHECK_EN adds aln_score.
// One-entry output register: a pair appears the cycle after its coordinate is accepted.
// in_ready follows the output slot (free or being drained), so out_ready stalls the input directly.
module nw_align_emitter
  import nw_pkg::*;
#(
  parameter int LENGTH      = 10,
  parameter int CWIDTH      = 2,
  parameter int CORD_LENGTH = NW_CORD_W,
  parameter int CNT_W       = CORD_LENGTH + 1
`ifdef NW_SCORE_CHECK_EN
  ,
  parameter int MATCH       = 1,
  parameter int MISMATCH    = -1,
  parameter int INDEL       = -1,
  parameter int SWIDTH      = 16
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [LENGTH*CWIDTH-1:0] s1,
  input  logic [LENGTH*CWIDTH-1:0] s2,
  input  logic [2*CORD_LENGTH-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [CWIDTH-1:0]        out_c1,
  output logic [CWIDTH-1:0]        out_c2,
  output logic                     out_gap1,
  output logic                     out_gap2,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         n_match,
  output logic [CNT_W-1:0]         n_mismatch,
  output logic [CNT_W-1:0]         n_gap,
  output logic [CNT_W-1:0]         aln_len,
  output logic                     done,
  output logic                     error
`ifdef NW_SCORE_CHECK_EN
  ,
  output logic signed [SWIDTH-1:0] aln_score
`endif
);

  localparam int                   IDX_W   = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam logic [NW_CORD_W-1:0] TOP_IDX = NW_CORD_W'(LENGTH - 1);

  emit_state_t       state;
  emit_state_t       state_n;
  coord_t            p;
  coord_t            c;
  logic [1:0]        mv;
  logic              legal;
  logic              slot_free;
  logic              load;
  logic              p_ld;
  logic              clr;
  logic [CWIDTH-1:0] ld_c1;
  logic [CWIDTH-1:0] ld_c2;
  logic              ld_g1;
  logic              ld_g2;
  logic              ld_last;
  logic [CWIDTH-1:0] s1_ch [LENGTH];
  logic [CWIDTH-1:0] s2_ch [LENGTH];

  // Character 0 sits in the most significant slot of each string.
  for (genvar i = 0; i < LENGTH; i++) begin : g_ch
    assign s1_ch[i] = s1[((LENGTH-1)-i)*CWIDTH +: CWIDTH];
    assign s2_ch[i] = s2[((LENGTH-1)-i)*CWIDTH +: CWIDTH];
  end

  assign c         = in_data;
  assign slot_free = !out_valid || out_ready;
  assign done      = (state == DONE);
  assign error     = (state == ERR);

  nw_step_decode #(
    .LENGTH(LENGTH)
  ) u_dec (
    .p    (p),
    .c    (c),
    .move (mv),
    .legal(legal)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    load     = 1'b0;
    p_ld     = 1'b0;
    clr      = 1'b0;
    ld_c1    = '0;
    ld_c2    = '0;
    ld_g1    = 1'b0;
    ld_g2    = 1'b0;
    ld_last  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (c.x != TOP_IDX || c.y != TOP_IDX) begin
            state_n = ERR;
          end else begin
            p_ld    = 1'b1;
            state_n = (LENGTH == 1) ? FLUSH : RUN;
          end
        end
      end
      RUN: begin
        in_ready = slot_free;
        if (in_valid && slot_free) begin
          if (!legal) begin
            state_n = ERR;
          end else begin
            load  = 1'b1;
            p_ld  = 1'b1;
            ld_c1 = (mv != MV_LEFT) ? s1_ch[p.y[IDX_W-1:0]] : '0;
            ld_c2 = (mv != MV_TOP)  ? s2_ch[p.x[IDX_W-1:0]] : '0;
            ld_g1 = (mv == MV_LEFT);
            ld_g2 = (mv == MV_TOP);
            if (c.x == '0 && c.y == '0) begin
              state_n = FLUSH;
            end
          end
        end
      end
      // Cell (0,0) has no successor coordinate; its diagonal pair is generated here.
      FLUSH: begin
        if (slot_free) begin
          load    = 1'b1;
          ld_c1   = s1_ch[0];
          ld_c2   = s2_ch[0];
          ld_last = 1'b1;
          state_n = LAST;
        end
      end
      LAST: begin
        if (out_valid && out_ready) begin
          state_n = DONE;
        end
      end
      DONE: begin
        if (start) begin
          clr     = 1'b1;
          state_n = IDLE;
        end
      end
      ERR: begin
        in_ready = 1'b1;
        if (start) begin
          clr     = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      p          <= '0;
      out_c1     <= '0;
      out_c2     <= '0;
      out_gap1   <= 1'b0;
      out_gap2   <= 1'b0;
      out_last   <= 1'b0;
      out_valid  <= 1'b0;
      n_match    <= '0;
      n_mismatch <= '0;
      n_gap      <= '0;
      aln_len    <= '0;
    end else begin
      if (p_ld) begin
        p <= c;
      end
      if (load) begin
        out_c1    <= ld_c1;
        out_c2    <= ld_c2;
        out_gap1  <= ld_g1;
        out_gap2  <= ld_g2;
        out_last  <= ld_last;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // Counters track loads, so they lead the consumer by at most one pair.
      if (clr) begin
        n_match    <= '0;
        n_mismatch <= '0;
        n_gap      <= '0;
        aln_len    <= '0;
      end else if (load) begin
        aln_len <= aln_len + CNT_W'(1);
        if (ld_g1 || ld_g2) begin
          n_gap <= n_gap + CNT_W'(1);
        end else if (ld_c1 == ld_c2) begin
          n_match <= n_match + CNT_W'(1);
        end else begin
          n_mismatch <= n_mismatch + CNT_W'(1);
        end
      end
    end
  end

`ifdef NW_SCORE_CHECK_EN
  localparam logic signed [SWIDTH-1:0] W_MATCH    = SWIDTH'(MATCH);
  localparam logic signed [SWIDTH-1:0] W_MISMATCH = SWIDTH'(MISMATCH);
  localparam logic signed [SWIDTH-1:0] W_INDEL    = SWIDTH'(INDEL);

  always_ff @(posedge clk) begin
    if (!reset) begin
      aln_score <= '0;
    end else if (clr) begin
      aln_score <= '0;
    end else if (load) begin
      if (ld_g1 || ld_g2) begin
        aln_score <= aln_score + W_INDEL;
      end else if (ld_c1 == ld_c2) begin
        aln_score <= aln_score + W_MATCH;
      end else begin
        aln_score <= aln_score + W_MISMATCH;
      end
    end
  end
`endif

  a_hold: assert property (@(posedge clk) disable iff (!reset)
    (out_valid && !out_ready) |=> (out_valid &&
      $stable({out_c1, out_c2, out_gap1, out_gap2, out_last})));

  a_len: assert property (@(posedge clk)
    aln_len == CNT_W'(n_match + n_mismatch + n_gap));

endmodule

// File: tb/tb_nw_align_emitter.sv
// Scoreboard bench for nw_align_emitter at LENGTH=4: legal streams with and without output stalls,
// malformed streams, start re-arm and mid-stream reset.
module tb_nw_align_emitter;

  localparam int L   = 4;
  localparam int CW  = 2;
  localparam int CL  = 8;
  localparam int CNW = CL + 1;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [L*CW-1:0] s1;
  logic [L*CW-1:0] s2;
  logic [2*CL-1:0] in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [CW-1:0]   out_c1;
  logic [CW-1:0]   out_c2;
  logic            out_gap1;
  logic            out_gap2;
  logic            out_last;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [CNW-1:0]  n_match;
  logic [CNW-1:0]  n_mismatch;
  logic [CNW-1:0]  n_gap;
  logic [CNW-1:0]  aln_len;
  logic            done;
  logic            error;
`ifdef NW_SCORE_CHECK_EN
  logic signed [15:0] aln_score;
`endif

  int total = 0;
  int bad   = 0;

  logic [6:0] exp_q[$];
  int em, emm, eg, esc;

  always #5 clk = ~clk;

  nw_align_emitter #(.LENGTH(L)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .s1        (s1),
    .s2        (s2),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_c1    (out_c1),
    .out_c2    (out_c2),
    .out_gap1  (out_gap1),
    .out_gap2  (out_gap2),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .n_match   (n_match),
    .n_mismatch(n_mismatch),
    .n_gap     (n_gap),
    .aln_len   (aln_len),
    .done      (done),
    .error     (error)
`ifdef NW_SCORE_CHECK_EN
    ,
    .aln_score (aln_score)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] get_ch(input logic [L*CW-1:0] s, input int idx);
    return s[((L-1)-idx)*CW +: CW];
  endfunction

  task automatic push_pair(input logic [CW-1:0] c1, input logic [CW-1:0] c2,
                           input logic g1, input logic g2, input logic last);
    exp_q.push_back({c1, c2, g1, g2, last});
    if (g1 || g2) begin
      eg++;
      esc -= 1;
    end else if (c1 == c2) begin
      em++;
      esc += 1;
    end else begin
      emm++;
      esc -= 1;
    end
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_match"}, n_match, em);
    chk({tag, "_mismatch"}, n_mismatch, emm);
    chk({tag, "_gap"}, n_gap, eg);
    chk({tag, "_len"}, aln_len, em + emm + eg);
`ifdef NW_SCORE_CHECK_EN
    chk({tag, "_score"}, aln_score, esc);
`endif
  endtask

  // mode 0: out_ready held high; mode 1: out_ready cycles 0,0,1,1.
  task automatic run_stream(input string tag, input logic [15:0] ws[$], input int mode,
                            input int abort_after);
    int idx = 0;
    int cyc = 0;
    int consumed = 0;
    int px = 0, py = 0, cx, cy;
    logic [7:0] prev = '0;
    logic [7:0] cur;
    logic prev_hold = 1'b0;
    logic acc;
    exp_q.delete();
    em = 0; emm = 0; eg = 0; esc = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = ws[0];
    while (idx < ws.size() || exp_q.size() != 0) begin
      @(negedge clk);
      cur = {out_valid, out_c1, out_c2, out_gap1, out_gap2, out_last};
      if (prev_hold) chk({tag, "_hold"}, cur, prev);
      if (idx > 0 && idx < ws.size()) chk({tag, "_in_ready"}, in_ready, !out_valid || out_ready);
      if (out_valid && out_ready) begin
        chk({tag, "_pair_expected"}, exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk({tag, "_pair"}, cur[6:0], exp_q.pop_front());
        consumed++;
      end
      prev_hold = out_valid && !out_ready;
      prev = cur;
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        cx = int'(ws[idx][15:8]);
        cy = int'(ws[idx][7:0]);
        if (idx != 0) begin
          if (px != cx && py != cy) push_pair(get_ch(s1, py), get_ch(s2, px), 1'b0, 1'b0, 1'b0);
          else if (py != cy) push_pair(get_ch(s1, py), '0, 1'b0, 1'b1, 1'b0);
          else push_pair('0, get_ch(s2, px), 1'b1, 1'b0, 1'b0);
          if (cx == 0 && cy == 0) push_pair(get_ch(s1, 0), get_ch(s2, 0), 1'b0, 1'b0, 1'b1);
        end
        px = cx;
        py = cy;
        idx++;
      end
      cyc++;
      if (abort_after != 0 && consumed >= abort_after) begin
        in_valid = 1'b0;
        return;
      end
      if (cyc > 300) begin
        chk({tag, "_timeout"}, exp_q.size(), 0);
        break;
      end
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 4) >= 2);
      in_valid = (idx < ws.size());
      if (in_valid) in_data = ws[idx];
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_err"}, error, 0);
    check_counts(tag);
  endtask

  task automatic send_word(input string tag, input logic [7:0] x, input logic [7:0] y);
    logic ok = 1'b0;
    logic a;
    in_data = {x, y};
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a = in_ready;
      @(posedge clk);
      #1;
      if (a) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    chk({tag, "_accepted"}, ok, 1);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] sa[$];
    logic [15:0] sb[$];
    sa = '{16'h0303, 16'h0202, 16'h0101, 16'h0000};
    sb = '{16'h0303, 16'h0302, 16'h0201, 16'h0100, 16'h0000};
    s1 = {2'd0, 2'd1, 2'd2, 2'd3};
    s2 = {2'd0, 2'd1, 2'd2, 2'd3};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_aln_len", aln_len, 0);
    chk("rst_n_match", n_match, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    run_stream("diag", sa, 0, 0);
    do_start();
    chk("start_done", done, 0);
    chk("start_len", aln_len, 0);
    chk("start_in_ready", in_ready, 1);

    run_stream("gaps", sb, 0, 0);
    do_start();
    s2 = {2'd3, 2'd1, 2'd0, 2'd2};
    run_stream("stall", sb, 1, 0);
    do_start();
    s2 = {2'd0, 2'd1, 2'd2, 2'd3};

    send_word("e1a", 8'd3, 8'd3);
    send_word("e1b", 8'd1, 8'd2);
    chk("e1_error", error, 1);
    chk("e1_out_valid", out_valid, 0);
    send_word("e1c", 8'd2, 8'd2);
    chk("e1_drop_valid", out_valid, 0);
    chk("e1_drop_len", aln_len, 0);
    do_start();
    chk("e1_restart_error", error, 0);
    chk("e1_restart_in_ready", in_ready, 1);

    send_word("e2a", 8'd3, 8'd3);
    send_word("e2b", 8'd2, 8'd2);
    send_word("e2c", 8'd2, 8'd3);
    chk("e2_error", error, 1);
    chk("e2_match", n_match, 1);
    chk("e2_len", aln_len, 1);
    @(posedge clk);
    #1;
    chk("e2_drained", out_valid, 0);
    do_start();
    chk("e2_clr_match", n_match, 0);
    chk("e2_clr_len", aln_len, 0);

    send_word("e3a", 8'd2, 8'd3);
    chk("e3_error", error, 1);
    for (int i = 0; i < 3; i++) begin
      send_word("e3_more", 8'd1, 8'd1);
      chk("e3_out_valid", out_valid, 0);
    end
    do_start();

    run_stream("abort", sa, 0, 2);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_len", aln_len, 0);
    chk("mrst_match", n_match, 0);
    chk("mrst_in_ready", in_ready, 1);
    reset = 1'b1;
    run_stream("fresh", sa, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nw_align_emitter.md
Name: nw_align_emitter

Overview:
- Downstream of the NW grid traceback.
- Consumes the traceback coordinate stream {x,y}, emitted from (LENGTH-1,LENGTH-1) down to (0,0), one coordinate per accepted word.
- Derives each step's move from the delta between consecutive coordinates and emits aligned character pairs (with gap flags) in reverse order (end to start).
- Keeps match, mismatch, gap and length counters, and flags malformed streams.

Parameters:
- LENGTH, 10, characters per string.
- CWIDTH, 2, bits per character.
- CORD_LENGTH, 8, bits per coordinate.
- CNT_W, CORD_LENGTH+1, counter width (max path length is 2*LENGTH-1).
- MATCH, 1, signed weight (used only with NW_SCORE_CHECK_EN).
- MISMATCH, -1, signed weight (NW_SCORE_CHECK_EN only).
- INDEL, -1, signed weight (NW_SCORE_CHECK_EN only).
- SWIDTH, 16, score width (NW_SCORE_CHECK_EN only).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low; reset==0 clears all state at the next clk edge.
- start  in  1  one-cycle pulse; re-arms from DONE or ERR to IDLE and clears counters.
- s1  in  LENGTH*CWIDTH  string 1; row y character is s1[((LENGTH-1)-y)*CWIDTH +: CWIDTH]; stable while busy.
- s2  in  LENGTH*CWIDTH  string 2; column x character is indexed the same way by x.
- in_data  in  2*CORD_LENGTH  coordinate word {x,y}; x in the upper half.
- in_valid  in  1  coordinate present.
- in_ready  out  1  coordinate accepted when in_valid&&in_ready.
- out_c1  out  CWIDTH  s1 character; 0 when out_gap1.
- out_c2  out  CWIDTH  s2 character; 0 when out_gap2.
- out_gap1  out  1  gap in s1 (LEFT move).
- out_gap2  out  1  gap in s2 (TOP move).
- out_last  out  1  pair for cell (0,0).
- out_valid  out  1  pair valid.
- out_ready  in  1  pair consumed when out_valid&&out_ready.
- n_match  out  CNT_W  diagonal pairs with equal characters.
- n_mismatch  out  CNT_W  diagonal pairs with unequal characters.
- n_gap  out  CNT_W  TOP plus LEFT pairs.
- aln_len  out  CNT_W  pairs emitted.
- done  out  1  final pair consumed.
- error  out  1  malformed stream detected.

Behaviour:
- Reset values: all outputs 0, except in_ready=1 in IDLE. State=IDLE; prev register p=0.
- Output register is one entry. Define slot_free = !out_valid || out_ready.
- IDLE:
  - in_ready=1.
  - On accept of c: if c != (LENGTH-1,LENGTH-1) -> ERR.
  - Else p<=c. If LENGTH==1 -> FLUSH, else -> RUN.
- RUN:
  - in_ready=slot_free.
  - On accept of c, compute dx=p.x-c.x and dy=p.y-c.y.
  - Legal iff dx,dy in {0,1}, not both 0, and c.x,c.y < LENGTH. Illegal -> ERR; no pair is loaded.
  - Legal dx=1,dy=1 (CORNER): load c1=s1[p.y], c2=s2[p.x].
  - Legal dx=0,dy=1 (TOP): load c1=s1[p.y], gap2=1.
  - Legal dx=1,dy=0 (LEFT): load c2=s2[p.x], gap1=1.
  - Then p<=c. If c==(0,0) -> FLUSH.
- FLUSH:
  - in_ready=0.
  - When slot_free: load the CORNER pair for (0,0) with out_last=1 -> LAST.
  - Cell (0,0) is always diagonal.
- LAST:
  - in_ready=0.
  - When the out_last pair is consumed: done<=1 -> DONE.
- DONE: in_ready=0, done=1. start -> IDLE with counters cleared and done=0.
- ERR:
  - error=1, in_ready=1; all further input is discarded.
  - out_valid drops once the pending pair is consumed; no new pairs are loaded.
  - start -> IDLE.
- start is ignored in IDLE, RUN, FLUSH and LAST.
- Counters update in the cycle a pair is loaded, not consumed. aln_len = n_match + n_mismatch + n_gap.
- Throughput: one pair per cycle with out_ready held high.
- out_* hold stable while out_valid && !out_ready.
- reset==0 mid-stream: immediate return to IDLE at that edge. Counters, done, error and out_valid are cleared.

Optional Feature:
- NW_SCORE_CHECK_EN defined:
  - Adds output aln_score (SWIDTH, signed, reset 0).
  - Accumulates MATCH, MISMATCH or INDEL per loaded pair.
  - On reaching DONE, equals the grid's cell (LENGTH-1,LENGTH-1) score for a legal path.
  - Cleared by start.
- NW_SCORE_CHECK_EN undefined: port and accumulator are absent; all else is identical.

Decomposition:
- Shared package nw_pkg:
  - move encoding MV_TOP=2'b00, MV_LEFT=2'b01, MV_CORNER=2'b10 (matches the grid direction codes);
  - emitter state enum (IDLE, RUN, FLUSH, LAST, DONE, ERR);
  - coordinate struct {x,y}.
- One sub-module: nw_step_decode.
  - Combinational.
  - Takes p, c and LENGTH; returns move and legal.

Test Plan:
- LENGTH=4, s1=s2={0,1,2,3}, stream (3,3),(2,2),(1,1),(0,0), out_ready=1 -> 4 CORNER pairs (3,3),(2,2),(1,1),(0,0); out_last on the 4th; n_match=4, aln_len=4, done=1, aln_score=4.
- LENGTH=4, stream (3,3),(3,2),(2,1),(1,0),(0,0) -> pairs TOP(c1=s1[3]), CORNER, CORNER, LEFT(c2=s2[1]), CORNER(0,0); n_gap=2, aln_len=5.
- Same stream with out_ready toggling 1,0,0,1,... -> no pair lost or duplicated; in_ready=0 while the slot is held; outputs stable under stall.
- Stream (3,3),(1,2) -> error=1 in the cycle after accept; no pair for (3,3); further inputs accepted and dropped; start -> IDLE, counters 0.
- First word (2,3) -> ERR immediately; out_valid never asserted.
- reset=0 after the 2nd pair -> the next cycle shows out_valid=0, counters 0, in_ready=1; a fresh full stream then completes correctly.
